// File: rtl/apb_master_ctrl.sv
// apb_master_ctrl: buffered APB requester.
// Commands from a valid/ready stream are queued in a small FIFO and issued one
// at a time as two-phase APB transfers; each transfer returns a response.
module apb_master_ctrl #(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int FIFO_DEPTH = 4
) (
    input  logic              pclk,
    input  logic              prst,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_write,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [DATA_W-1:0] cmd_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic              rsp_write,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              psel,
    output logic              penable,
    output logic              pwrite,
    output logic [ADDR_W-1:0] paddr,
    output logic [DATA_W-1:0] pwdata,
    input  logic [DATA_W-1:0] prdata,
    output logic              busy
);

    localparam int IW = $clog2(FIFO_DEPTH);

    typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP} state_t;

    state_t state, next_state;

    logic [IW:0]       wr_ptr, rd_ptr;
    logic [ADDR_W-1:0] fifo_addr  [FIFO_DEPTH];
    logic [DATA_W-1:0] fifo_wdata [FIFO_DEPTH];
    logic              fifo_write [FIFO_DEPTH];
    logic              full, empty, push, pop;

    // The extra pointer MSB distinguishes full from empty when indices match.
    assign empty     = (wr_ptr == rd_ptr);
    assign full      = (wr_ptr[IW] != rd_ptr[IW]) && (wr_ptr[IW-1:0] == rd_ptr[IW-1:0]);
    assign cmd_ready = !full && !prst;
    assign push      = cmd_valid && cmd_ready;
    assign busy      = (state != IDLE) || !empty;

    // FIFO pointers advance on push and pop.
    always_ff @(posedge pclk or posedge prst) begin
        if (prst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    // FIFO storage needs no reset; the pointers define what is valid.
    always_ff @(posedge pclk) begin
        if (push) begin
            fifo_addr[wr_ptr[IW-1:0]]  <= cmd_addr;
            fifo_wdata[wr_ptr[IW-1:0]] <= cmd_wdata;
            fifo_write[wr_ptr[IW-1:0]] <= cmd_write;
        end
    end

    // State register.
    always_ff @(posedge pclk or posedge prst) begin
        if (prst) state <= IDLE;
        else      state <= next_state;
    end

    // Next-state logic and FIFO pop decision.
    always_comb begin
        next_state = state;
        pop        = 1'b0;
        case (state)
            IDLE: begin
                if (!empty) begin
                    pop        = 1'b1;
                    next_state = SETUP;
                end
            end
            SETUP:  next_state = ACCESS;
            ACCESS: next_state = RESP;
            RESP: begin
                if (rsp_ready) begin
                    if (!empty) begin
                        pop        = 1'b1;
                        next_state = SETUP;
                    end else begin
                        next_state = IDLE;
                    end
                end
            end
            default: next_state = IDLE;
        endcase
    end

    // Registered APB and response outputs, driven from the current phase.
    always_ff @(posedge pclk or posedge prst) begin
        if (prst) begin
            psel      <= 1'b0;
            penable   <= 1'b0;
            pwrite    <= 1'b0;
            paddr     <= '0;
            pwdata    <= '0;
            rsp_valid <= 1'b0;
            rsp_write <= 1'b0;
            rsp_rdata <= '0;
        end else begin
            if (pop) begin
                paddr  <= fifo_addr[rd_ptr[IW-1:0]];
                pwrite <= fifo_write[rd_ptr[IW-1:0]];
                pwdata <= fifo_write[rd_ptr[IW-1:0]] ? fifo_wdata[rd_ptr[IW-1:0]] : '0;
                psel   <= 1'b1;
            end
            case (state)
                SETUP: penable <= 1'b1;
                ACCESS: begin
                    rsp_rdata <= pwrite ? '0 : prdata;
                    rsp_write <= pwrite;
                    rsp_valid <= 1'b1;
                    psel      <= 1'b0;
                    penable   <= 1'b0;
                end
                RESP: begin
                    if (rsp_ready) rsp_valid <= 1'b0;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_apb_master_ctrl.sv
// tb_apb_master_ctrl: scoreboard bench for apb_master_ctrl.
// Stimulus pushes expected APB transfers and responses into queues; a monitor
// pops and compares them whenever the DUT presents an ACCESS phase or response.
module tb_apb_master_ctrl;

    logic        pclk;
    logic        prst;
    logic        cmd_valid;
    logic        cmd_ready;
    logic        cmd_write;
    logic [31:0] cmd_addr;
    logic [31:0] cmd_wdata;
    logic        rsp_valid;
    logic        rsp_ready;
    logic        rsp_write;
    logic [31:0] rsp_rdata;
    logic        psel;
    logic        penable;
    logic        pwrite;
    logic [31:0] paddr;
    logic [31:0] pwdata;
    logic [31:0] prdata;
    logic        busy;

    typedef struct packed {
        logic        write;
        logic [31:0] addr;
        logic [31:0] data;
    } exp_t;

    exp_t apb_q[$];
    exp_t rsp_q[$];

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    logic prev_psel = 1'b0;

    apb_master_ctrl dut (
        .pclk      (pclk),
        .prst      (prst),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_write (cmd_write),
        .cmd_addr  (cmd_addr),
        .cmd_wdata (cmd_wdata),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_write (rsp_write),
        .rsp_rdata (rsp_rdata),
        .psel      (psel),
        .penable   (penable),
        .pwrite    (pwrite),
        .paddr     (paddr),
        .pwdata    (pwdata),
        .prdata    (prdata),
        .busy      (busy)
    );

    // Zero-wait slave: returns address ^ 0x89 only during ACCESS, junk otherwise.
    assign prdata = (psel && penable) ? (paddr ^ 32'h0000_0089) : 32'hDEAD_BEEF;

    // Free-running clock and cycle counter.
    initial pclk = 1'b0;
    always #5 pclk = ~pclk;
    always @(posedge pclk) cyc <= cyc + 1;

    task automatic check_output(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Offer one command, wait (bounded) for acceptance and record expectations.
    task automatic apply_stimulus(input logic write, input logic [31:0] addr,
                                  input logic [31:0] wdata, output int acc_cyc);
        logic accepted;
        exp_t e;
        accepted  = 1'b0;
        acc_cyc   = -1;
        cmd_write = write;
        cmd_addr  = addr;
        cmd_wdata = wdata;
        cmd_valid = 1'b1;
        for (int n = 0; n < 200 && !accepted; n++) begin
            @(negedge pclk);
            accepted = cmd_ready;
            @(posedge pclk);
            #1;
        end
        cmd_valid = 1'b0;
        if (accepted) begin
            acc_cyc = cyc;
            e.write = write;
            e.addr  = addr;
            e.data  = write ? wdata : 32'h0;
            apb_q.push_back(e);
            e.data  = write ? 32'h0 : (addr ^ 32'h0000_0089);
            rsp_q.push_back(e);
        end else begin
            checks++;
            errors++;
            $display("[TB] FAIL cmd_accept_timeout: got cmd_ready=0 expected acceptance for addr 0x%0h", addr);
        end
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while ((busy || rsp_q.size() != 0) && n < 300) begin
            @(posedge pclk);
            #1;
            n++;
        end
        if (n >= 300) begin
            checks++;
            errors++;
            $display("[TB] FAIL idle_timeout: got busy=%0d pending=%0d expected idle", busy, rsp_q.size());
        end
    endtask

    // Monitor: protocol rule, ACCESS-phase contents and response contents.
    always @(negedge pclk) begin
        exp_t e;
        if (prst) begin
            prev_psel = 1'b0;
        end else begin
            if (penable) begin
                check_output("penable_after_psel", {prev_psel, psel}, 2'b11);
            end
            if (psel && penable) begin
                if (apb_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("[TB] FAIL apb_unexpected: got transfer addr 0x%0h expected none", paddr);
                end else begin
                    e = apb_q.pop_front();
                    check_output("apb_paddr", paddr, e.addr);
                    check_output("apb_pwrite", pwrite, e.write);
                    check_output("apb_pwdata", pwdata, e.data);
                end
            end
            if (rsp_valid && rsp_ready) begin
                if (rsp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("[TB] FAIL rsp_unexpected: got response rdata 0x%0h expected none", rsp_rdata);
                end else begin
                    e = rsp_q.pop_front();
                    check_output("rsp_write", rsp_write, e.write);
                    check_output("rsp_rdata", rsp_rdata, e.data);
                end
            end
            prev_psel = psel;
        end
    end

    // Directed test sequence.
    initial begin
        int acc;
        int start;
        prst      = 1'b1;
        cmd_valid = 1'b0;
        cmd_write = 1'b0;
        cmd_addr  = '0;
        cmd_wdata = '0;
        rsp_ready = 1'b1;

        // Reset values.
        #3;
        check_output("rst_psel", psel, 0);
        check_output("rst_penable", penable, 0);
        check_output("rst_pwrite", pwrite, 0);
        check_output("rst_rsp_valid", rsp_valid, 0);
        check_output("rst_rsp_write", rsp_write, 0);
        check_output("rst_paddr", paddr, 0);
        check_output("rst_pwdata", pwdata, 0);
        check_output("rst_rsp_rdata", rsp_rdata, 0);
        check_output("rst_busy", busy, 0);
        check_output("rst_cmd_ready", cmd_ready, 0);
        repeat (3) @(posedge pclk);
        #1 prst = 1'b0;
        #1 check_output("post_rst_cmd_ready", cmd_ready, 1);

        // Single write: latency N+2 SETUP, N+3 ACCESS, N+4 response.
        apply_stimulus(1'b1, 32'h04, 32'hA5, acc);
        check_output("wr_n1_psel", psel, 0);
        @(posedge pclk); #1;
        check_output("wr_n2_setup", {psel, penable}, 2'b10);
        @(posedge pclk); #1;
        check_output("wr_n3_access", {psel, penable}, 2'b11);
        check_output("wr_n3_paddr", paddr, 32'h04);
        check_output("wr_n3_pwdata", pwdata, 32'hA5);
        @(posedge pclk); #1;
        check_output("wr_n4_rsp_valid", rsp_valid, 1);
        check_output("wr_n4_psel", psel, 0);
        check_output("wr_n4_rsp_write", rsp_write, 1);
        check_output("wr_n4_rsp_rdata", rsp_rdata, 0);
        wait_idle();

        // Single read with non-zero wdata that must not reach pwdata.
        apply_stimulus(1'b0, 32'h08, 32'hFFFF_FFFF, acc);
        wait_idle();

        // Fill: response stalled, 1 in flight plus FIFO_DEPTH queued.
        rsp_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            apply_stimulus(i % 2 == 0, 32'h10 + 32'(4 * i), 32'h1000 + 32'(i), acc);
        end
        check_output("fill_cmd_ready", cmd_ready, 0);
        cmd_write = 1'b0;
        cmd_addr  = 32'h24;
        cmd_wdata = 32'h1005;
        cmd_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge pclk); #1;
            check_output("full_hold_cmd_ready", cmd_ready, 0);
            check_output("full_hold_rsp_valid", rsp_valid, 1);
        end
        // Push offered on the same edge as the pop: taken only on the next edge.
        rsp_ready = 1'b1;
        start = cyc;
        apply_stimulus(1'b0, 32'h24, 32'h1005, acc);
        check_output("push_at_pop_delay", acc - start, 2);
        check_output("refull_cmd_ready", cmd_ready, 0);
        for (int i = 6; i < 10; i++) begin
            apply_stimulus(i % 2 == 0, 32'h10 + 32'(4 * i), 32'h1000 + 32'(i), acc);
        end
        wait_idle();

        // Back-to-back reads: psel 1,1,0 and rsp_valid 0,0,1 repeating.
        fork
            begin
                apply_stimulus(1'b0, 32'h80, 32'h0, acc);
                apply_stimulus(1'b0, 32'h84, 32'h0, acc);
                apply_stimulus(1'b0, 32'h88, 32'h0, acc);
            end
            begin
                for (int k = 0; k < 20 && !psel; k++) begin
                    @(posedge pclk); #1;
                end
                for (int i = 0; i < 9; i++) begin
                    check_output("b2b_psel", psel, (i % 3) != 2);
                    check_output("b2b_rsp_valid", rsp_valid, (i % 3) == 2);
                    @(posedge pclk); #1;
                end
            end
        join
        wait_idle();

        // Reset during ACCESS with more commands queued.
        rsp_ready = 1'b0;
        apply_stimulus(1'b1, 32'h40, 32'h11, acc);
        apply_stimulus(1'b1, 32'h44, 32'h22, acc);
        apply_stimulus(1'b1, 32'h48, 32'h33, acc);
        for (int k = 0; k < 10 && !penable; k++) begin
            @(posedge pclk); #1;
        end
        check_output("pre_rst_penable", penable, 1);
        #2 prst = 1'b1;
        #1;
        check_output("async_rst_psel", psel, 0);
        check_output("async_rst_penable", penable, 0);
        check_output("async_rst_rsp_valid", rsp_valid, 0);
        check_output("async_rst_busy", busy, 0);
        check_output("async_rst_cmd_ready", cmd_ready, 0);
        apb_q.delete();
        rsp_q.delete();
        repeat (2) @(posedge pclk);
        #1 prst = 1'b0;
        rsp_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(posedge pclk); #1;
            check_output("post_rst_psel", psel, 0);
            check_output("post_rst_busy", busy, 0);
        end

        check_output("apb_q_drained", apb_q.size(), 0);
        check_output("rsp_q_drained", rsp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
